hash_core_arbiter: RTL and testbench

HASH_CORE_ARBITER -- requirements
Module: hash_core_arbiter

---
 rtl/hash_core_arbiter.sv | 151 +++++++++++++++
 tb/tb_hash_core_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_core_arbiter.sv
// Round-robin arbiter that shares one hash core among NREQ requesters.
// Optional BUSY-state watchdog enabled by defining HASH_ARB_TIMEOUT_EN.
module hash_core_arbiter #(
  parameter int  NREQ    = 4,
  parameter int  MSG_W   = 1024,
  parameter int  DIG_W   = 256,
  parameter int  TIMEOUT = 255,
  localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*MSG_W-1:0]   req_msg,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err,
  output logic [DIG_W-1:0]        digest,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id,
  output logic [MSG_W-1:0]        h_msg,
  output logic                    h_start,
  input  logic [DIG_W-1:0]        h_value,
  input  logic                    h_end
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   win_id;
  logic              win_valid;
  logic [MSG_W-1:0]  win_msg;
  logic              do_grant;
  logic              do_finish;
  logic              timeout_hit;

  // Search starts just past the last served requester, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_valid = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign win_msg = req_msg[win_id*MSG_W +: MSG_W];
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_finish = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          do_grant  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (h_end) begin
          do_finish = 1'b1;
          state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Wait for the core to drop its flag so a stale h_end is never taken as a new result.
        if (!h_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= ID_W'(NREQ - 1);
      grant_id <= '0;
      h_msg    <= '0;
      h_start  <= 1'b0;
      digest   <= '0;
      done     <= '0;
    end else begin
      done <= '0;
      if (do_grant) begin
        h_msg    <= win_msg;
        grant_id <= win_id;
        h_start  <= 1'b1;
      end
      if (do_finish || timeout_hit) begin
        h_start <= 1'b0;
        ptr     <= grant_id;
      end
      if (do_finish) begin
        digest         <= h_value;
        done[grant_id] <= 1'b1;
      end
    end
  end

`ifdef HASH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt;

  // Fires on the edge that would bring the count to TIMEOUT.
  assign timeout_hit = (state == BUSY) && !h_end && ((int'(to_cnt) + 1) == TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
      err    <= '0;
    end else begin
      err <= '0;
      if (do_grant) begin
        to_cnt <= '0;
      end else if (state == BUSY) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (timeout_hit) err[grant_id] <= 1'b1;
    end
  end
`else
  // Without the watchdog the timeout limit has no consumer.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign err            = '0;
`endif

endmodule

// File: tb/tb_hash_core_arbiter.sv
// Scoreboard bench for hash_core_arbiter with a behavioural hash core model.
// Timeout scenario is exercised only when HASH_ARB_TIMEOUT_EN is defined.
module tb_hash_core_arbiter;

  localparam int NREQ    = 4;
  localparam int MSG_W   = 64;
  localparam int DIG_W   = 64;
  localparam int TIMEOUT = 20;
  localparam int LAT     = 10;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*MSG_W-1:0] req_msg;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       err;
  logic [DIG_W-1:0]      digest;
  logic                  busy;
  logic [1:0]            grant_id;
  logic [MSG_W-1:0]      h_msg;
  logic                  h_start;
  logic [DIG_W-1:0]      h_value;
  logic                  h_end;
  logic                  core_hang;

  typedef struct packed {
    logic [1:0]       id;
    logic [DIG_W-1:0] dig;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  hash_core_arbiter #(
    .NREQ(NREQ), .MSG_W(MSG_W), .DIG_W(DIG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_msg(req_msg),
    .done(done), .err(err), .digest(digest), .busy(busy),
    .grant_id(grant_id), .h_msg(h_msg), .h_start(h_start),
    .h_value(h_value), .h_end(h_end)
  );

  always #5 clk = ~clk;

  function automatic logic [DIG_W-1:0] hash_fn(input logic [MSG_W-1:0] m);
    return {m[31:0], m[63:32]} ^ 64'h5A5A_0F0F_3C3C_9696;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic set_slice(input int i, input logic [MSG_W-1:0] m);
    req_msg[i*MSG_W +: MSG_W] = m;
  endtask

  task automatic push_job(input int i, input logic [MSG_W-1:0] m);
    exp_t e;
    set_slice(i, m);
    e.id  = 2'(i);
    e.dig = hash_fn(m);
    exp_q.push_back(e);
  endtask

  task automatic wait_h_start(input string tag);
    int n;
    n = 0;
    while (!h_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, h_start, 1);
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, (exp_q.size() != 0) || busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Hash core: raises h_end after LAT cycles of h_start, drops it once h_start falls.
  initial begin
    int cyc;
    cyc     = 0;
    h_end   = 1'b0;
    h_value = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!h_start) begin
        h_end = 1'b0;
        cyc   = 0;
      end else if (!h_end && !core_hang) begin
        cyc++;
        if (cyc == LAT) begin
          h_end   = 1'b1;
          h_value = hash_fn(h_msg);
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every done pulse and drops the served request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if ((done & err) != 0) check("done_err_overlap", done & err, 0);
        if (done != 0) begin
          check("done_onehot", $onehot(done), 1);
          if (exp_q.size() == 0) begin
            check("done_unexpected", done, 0);
          end else begin
            e = exp_q.pop_front();
            check("done_id", done, 64'(4'b0001 << e.id));
            check("grant_id", grant_id, e.id);
            check("digest", digest, e.dig);
          end
          req = req & ~done;
        end
`ifdef HASH_ARB_TIMEOUT_EN
        if (err != 0) begin
          check("err_onehot", $onehot(err), 1);
          req = req & ~err;
        end
`else
        if (err != 0) check("err_tied_low", err, 0);
`endif
      end
    end
  end

  initial begin
    logic [MSG_W-1:0] msg_a;
    logic [MSG_W-1:0] msg_c;
    logic [DIG_W-1:0] dig_saved;
    int n;

    reset     = 1'b0;
    req       = '0;
    req_msg   = '0;
    core_hang = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_h_start", h_start, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_digest", digest, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_h_msg", h_msg, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single job on requester 0 with a 10-cycle core latency.
    msg_a = 64'hA11C_E000_1234_5678;
    push_job(0, msg_a);
    req[0] = 1'b1;
    @(negedge clk);
    check("t1_h_start_rise", h_start, 1);
    check("t1_h_msg", h_msg, msg_a);
    n = 0;
    while (h_start && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t1_h_start_cycles", n, LAT);
    check("t1_digest", digest, hash_fn(msg_a));
    @(negedge clk);
    check("t1_busy_low", busy, 0);

    // All four requesting after reset: served 0, 1, 2, 3.
    do_reset();
    for (int i = 0; i < NREQ; i++) push_job(i, {$urandom, $urandom});
    req = 4'b1111;
    wait_drained("t2");
    check("t2_req_cleared", req, 0);

    // Move ptr to 1, then 0 and 1 together: search 2, 3, 0 grants 0 first.
    push_job(1, {$urandom, $urandom});
    req = 4'b0010;
    wait_drained("t3a");
    push_job(0, {$urandom, $urandom});
    push_job(1, {$urandom, $urandom});
    req = 4'b0011;
    wait_drained("t3b");

    // Requester 2 changes its block and drops req mid-job.
    msg_c = 64'hC0DE_CAFE_F00D_0002;
    push_job(2, msg_c);
    req[2] = 1'b1;
    wait_h_start("t4");
    repeat (3) @(negedge clk);
    set_slice(2, ~msg_c);
    req[2] = 1'b0;
    @(negedge clk);
    check("t4_h_msg_held", h_msg, msg_c);
    wait_drained("t4");

    // Reset mid-job discards the job; no done pulse may follow.
    set_slice(3, {$urandom, $urandom});
    req[3] = 1'b1;
    wait_h_start("t5");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_h_start", h_start, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_idle_after", busy, 0);

    // After reset ptr restarts at NREQ-1: requester 0 goes before 2.
    push_job(0, {$urandom, $urandom});
    push_job(2, {$urandom, $urandom});
    req = 4'b0101;
    wait_drained("t5r");

`ifdef HASH_ARB_TIMEOUT_EN
    // Core never finishes: watchdog fires TIMEOUT cycles after h_start rose.
    dig_saved = digest;
    core_hang = 1'b1;
    req[1]    = 1'b1;
    wait_h_start("t6");
    n = 0;
    while (err == 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t6_err_cycles", n, TIMEOUT);
    check("t6_err_id", err, 4'b0010);
    check("t6_no_done", done, 0);
    check("t6_h_start_low", h_start, 0);
    check("t6_digest_kept", digest, dig_saved);
    core_hang = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_idle_after", busy, 0);
`else
    dig_saved = digest;
    check("final_digest", dig_saved, hash_fn(req_msg[2*MSG_W +: MSG_W]));
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
